// File: rtl/archel_pkg.sv
// Shared constants, types and helpers for the archel VGA pattern generator.
package archel_pkg;

    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_TOTAL = 800;
    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_TOTAL = 525;

    localparam int COLOR_W = 5;
    localparam int GEN_W   = 8;
    localparam int CNT_W   = 10;

    localparam logic [6:0] VGA_IDLE = 7'b1100000;

    // Checkerboard of 16x16 tiles whose palette index rolls with the generation.
    function automatic logic [COLOR_W-1:0] pattern_color(
        input logic [CNT_W-1:0] h,
        input logic [CNT_W-1:0] v,
        input logic [GEN_W-1:0] gen
    );
        return (h[8:4] ^ v[8:4]) + gen[4:0];
    endfunction

endpackage

// File: rtl/archel_vga_timing.sv
// Horizontal/vertical raster counters with sync decode, visible flag and frame-end strobe.
module archel_vga_timing
    import archel_pkg::*;
#(
    parameter int P_H_VIS   = H_VIS,
    parameter int P_H_FP    = H_FP,
    parameter int P_H_SYNC  = H_SYNC,
    parameter int P_H_TOTAL = H_TOTAL,
    parameter int P_V_VIS   = V_VIS,
    parameter int P_V_FP    = V_FP,
    parameter int P_V_SYNC  = V_SYNC,
    parameter int P_V_TOTAL = V_TOTAL
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] o_h,
    output logic [CNT_W-1:0] o_v,
    output logic             o_hs_n,
    output logic             o_vs_n,
    output logic             o_visible,
    output logic             o_frame_end
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(P_H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(P_V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VEND  = CNT_W'(P_H_VIS);
    localparam logic [CNT_W-1:0] V_VEND  = CNT_W'(P_V_VIS);
    localparam logic [CNT_W-1:0] H_SS    = CNT_W'(P_H_VIS + P_H_FP);
    localparam logic [CNT_W-1:0] H_SE    = CNT_W'(P_H_VIS + P_H_FP + P_H_SYNC);
    localparam logic [CNT_W-1:0] V_SS    = CNT_W'(P_V_VIS + P_V_FP);
    localparam logic [CNT_W-1:0] V_SE    = CNT_W'(P_V_VIS + P_V_FP + P_V_SYNC);

    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic             w_h_last;
    logic             w_v_last;

    assign w_h_last = (r_h == H_LAST);
    assign w_v_last = (r_v == V_LAST);

    // Raster position: h wraps every line, v advances on each line wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_h_last) begin
            r_h <= '0;
            r_v <= w_v_last ? '0 : (r_v + CNT_ONE);
        end else begin
            r_h <= r_h + CNT_ONE;
        end
    end

    assign o_h         = r_h;
    assign o_v         = r_v;
    assign o_hs_n      = ~((r_h >= H_SS) && (r_h < H_SE));
    assign o_vs_n      = ~((r_v >= V_SS) && (r_v < V_SE));
    assign o_visible   = (r_h < H_VEND) && (r_v < V_VEND);
    assign o_frame_end = w_h_last && w_v_last;

endmodule

// File: rtl/archel.sv
// archel top: animated tile pattern over VGA timing with pause/single-step control.
// Optional white one-pixel frame border when ARCHEL_BORDER_EN is defined.
module archel
    import archel_pkg::*;
#(
    parameter int P_H_VIS   = H_VIS,
    parameter int P_H_FP    = H_FP,
    parameter int P_H_SYNC  = H_SYNC,
    parameter int P_H_TOTAL = H_TOTAL,
    parameter int P_V_VIS   = V_VIS,
    parameter int P_V_FP    = V_FP,
    parameter int P_V_SYNC  = V_SYNC,
    parameter int P_V_TOTAL = V_TOTAL
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PAUSE,
    input  logic       STEP,
    output logic [6:0] VGA
);

    localparam logic [GEN_W-1:0] GEN_ONE = GEN_W'(1);

    logic [CNT_W-1:0]   w_h;
    logic [CNT_W-1:0]   w_v;
    logic               w_hs_n;
    logic               w_vs_n;
    logic               w_visible;
    logic               w_frame_end;
    logic               w_step_edge;
    logic [COLOR_W-1:0] w_color;

    logic               r_step_s1;
    logic               r_step_s2;
    logic               r_step_d;
    logic               r_pend;
    logic [GEN_W-1:0]   r_gen;
    logic [6:0]         r_vga;

    archel_vga_timing #(
        .P_H_VIS  (P_H_VIS),
        .P_H_FP   (P_H_FP),
        .P_H_SYNC (P_H_SYNC),
        .P_H_TOTAL(P_H_TOTAL),
        .P_V_VIS  (P_V_VIS),
        .P_V_FP   (P_V_FP),
        .P_V_SYNC (P_V_SYNC),
        .P_V_TOTAL(P_V_TOTAL)
    ) u_timing (
        .clk        (CLK),
        .rst        (RST),
        .o_h        (w_h),
        .o_v        (w_v),
        .o_hs_n     (w_hs_n),
        .o_vs_n     (w_vs_n),
        .o_visible  (w_visible),
        .o_frame_end(w_frame_end)
    );

    // STEP is asynchronous to CLK: two-flop synchroniser plus edge history.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_step_s1 <= 1'b0;
            r_step_s2 <= 1'b0;
            r_step_d  <= 1'b0;
        end else begin
            r_step_s1 <= STEP;
            r_step_s2 <= r_step_s1;
            r_step_d  <= r_step_s2;
        end
    end

    assign w_step_edge = r_step_s2 & ~r_step_d;

    // Generation only moves at frame end; an edge landing on frame end arms the next one.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_gen  <= '0;
            r_pend <= 1'b0;
        end else if (w_frame_end) begin
            if (!PAUSE || r_pend) begin
                r_gen <= r_gen + GEN_ONE;
            end
            r_pend <= PAUSE & w_step_edge;
        end else if (PAUSE && w_step_edge) begin
            r_pend <= 1'b1;
        end
    end

`ifdef ARCHEL_BORDER_EN
    logic w_border;
    assign w_border = (w_h == '0) || (w_h == CNT_W'(P_H_VIS - 1)) ||
                      (w_v == '0) || (w_v == CNT_W'(P_V_VIS - 1));
`endif

    // Pixel colour for the current raster position.
    always_comb begin
        w_color = '0;
        if (!w_visible) begin
            w_color = '0;
`ifdef ARCHEL_BORDER_EN
        end else if (w_border) begin
            w_color = 5'b11111;
`endif
        end else begin
            w_color = pattern_color(w_h, w_v, r_gen);
        end
    end

    // One register stage keeps sync and colour aligned.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_vga <= VGA_IDLE;
        end else begin
            r_vga <= {w_hs_n, w_vs_n, w_color};
        end
    end

    assign VGA = r_vga;

endmodule

// File: tb/tb_archel.sv
// Randomised self-checking bench for archel: full-size and reduced-raster instances
// against a cycle-count based reference model, plus directed pause/step scenarios.
module tb_archel;

    localparam int S_HV = 32, S_HFP = 4, S_HS = 8, S_HT = 48;
    localparam int S_VV = 20, S_VFP = 2, S_VS = 2, S_VT = 26;
    localparam int S_FT = S_HT * S_VT;
`ifdef ARCHEL_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pause = 1'b0;
    logic       step = 1'b0;
    logic [6:0] vga_full;
    logic [6:0] vga_small;

    always #5 clk = ~clk;

    archel dut_full (
        .CLK(clk), .RST(rst), .PAUSE(pause), .STEP(step), .VGA(vga_full)
    );

    archel #(
        .P_H_VIS(S_HV), .P_H_FP(S_HFP), .P_H_SYNC(S_HS), .P_H_TOTAL(S_HT),
        .P_V_VIS(S_VV), .P_V_FP(S_VFP), .P_V_SYNC(S_VS), .P_V_TOTAL(S_VT)
    ) dut_small (
        .CLK(clk), .RST(rst), .PAUSE(pause), .STEP(step), .VGA(vga_small)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    // reference model configuration: index 0 = full raster, 1 = reduced raster
    int hv_c[2]  = '{640, S_HV};
    int hfp_c[2] = '{16,  S_HFP};
    int hs_c[2]  = '{96,  S_HS};
    int ht_c[2]  = '{800, S_HT};
    int vv_c[2]  = '{480, S_VV};
    int vfp_c[2] = '{10,  S_VFP};
    int vs_c[2]  = '{2,   S_VS};
    int vt_c[2]  = '{525, S_VT};

    int         n_m[2];
    int         gen_m[2];
    bit         pend_m[2];
    int         lh[2];
    int         lv[2];
    logic [6:0] exp_v[2];
    bit         p1, p2, p3;

    int         hs_cnt = 0, hs_cyc = 0, hs_lines = 0;
    int         vs_cnt = 0, vs_cyc = 0, vs_frames = 0;
    int         fr_s = -1;
    bit         phase_a = 1'b0;
    bit         cap_new = 1'b0;
    logic [4:0] cap_g;

    function automatic logic [6:0] ref_pixel(input int d, input int h, input int v, input int g);
        logic hs, vs;
        int c;
        hs = !((h >= hv_c[d] + hfp_c[d]) && (h < hv_c[d] + hfp_c[d] + hs_c[d]));
        vs = !((v >= vv_c[d] + vfp_c[d]) && (v < vv_c[d] + vfp_c[d] + vs_c[d]));
        c = 0;
        if (h < hv_c[d] && v < vv_c[d]) begin
            c = ((((h / 16) % 32) ^ ((v / 16) % 32)) + g) % 32;
            if (BORDER && (h == 0 || h == hv_c[d] - 1 || v == 0 || v == vv_c[d] - 1)) c = 31;
        end
        return {hs, vs, 5'(c)};
    endfunction

    task automatic model_step();
        int h, v;
        bit edge_det;
        edge_det = p2 && !p3;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                exp_v[d] = 7'b1100000;
                n_m[d] = 0; gen_m[d] = 0; pend_m[d] = 1'b0;
                lh[d] = -1; lv[d] = -1;
            end else begin
                h = n_m[d] % ht_c[d];
                v = n_m[d] / ht_c[d];
                lh[d] = h; lv[d] = v;
                exp_v[d] = ref_pixel(d, h, v, gen_m[d]);
                if (n_m[d] == ht_c[d] * vt_c[d] - 1) begin
                    if (!pause || pend_m[d]) gen_m[d] = (gen_m[d] + 1) % 256;
                    pend_m[d] = pause && edge_det;
                end else if (pause && edge_det) begin
                    pend_m[d] = 1'b1;
                end
                n_m[d] = (n_m[d] + 1) % (ht_c[d] * vt_c[d]);
            end
        end
        if (rst) begin
            p1 = 1'b0; p2 = 1'b0; p3 = 1'b0;
        end else begin
            p3 = p2; p2 = p1; p1 = step;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        model_step();
        check("vga_full", vga_full, exp_v[0]);
        check("vga_small", vga_small, exp_v[1]);
        if (rst) begin
            hs_cnt = 0; hs_cyc = 0; vs_cnt = 0; vs_cyc = 0; fr_s = -1;
        end else begin
            hs_cyc++;
            if (!vga_full[6]) hs_cnt++;
            if (hs_cyc == 800) begin
                if (hs_lines < 4) check("hs_low_per_line", hs_cnt, 96);
                hs_lines++; hs_cyc = 0; hs_cnt = 0;
            end
            vs_cyc++;
            if (!vga_small[5]) vs_cnt++;
            if (vs_cyc == S_FT) begin
                if (vs_frames < 3) check("vs_low_per_frame", vs_cnt, S_VS * S_HT);
                vs_frames++; vs_cyc = 0; vs_cnt = 0;
            end
            if (lh[1] == 0 && lv[1] == 0) fr_s++;
            if (lh[0] == 0 && lv[0] == 0)   check("pix_full_0_0", vga_full[4:0], BORDER ? 31 : 0);
            if (lh[0] == 16 && lv[0] == 0)  check("pix_full_16_0", vga_full[4:0], BORDER ? 31 : 1);
            if (lh[0] == 16 && lv[0] == 16) check("pix_full_16_16", vga_full[4:0], 0);
            if (phase_a && fr_s == 1 && lh[1] == 0 && lv[1] == 0)
                check("pix_small_f1_0_0", vga_small[4:0], BORDER ? 31 : 1);
            if (phase_a && fr_s == 0 && lh[1] == S_HV - 1 && lv[1] == S_VV - 1)
                check("pix_small_corner", vga_small[4:0], BORDER ? 31 : 0);
            if (lh[1] == 16 && lv[1] == 16) begin
                cap_g = vga_small[4:0];
                cap_new = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    // Run until the reduced raster shows tile (16,16), whose colour equals gen mod 32.
    task automatic next_cap(output logic [4:0] g);
        int budget;
        budget = 2 * S_FT + 10;
        cap_new = 1'b0;
        while (!cap_new && budget > 0) begin
            cyc();
            budget--;
        end
        check("cap_seen", {31'b0, cap_new}, 1);
        g = cap_g;
    endtask

    initial begin
        logic [4:0] g0, g;
        int budget;

        rst = 1'b1; pause = 1'b0; step = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        phase_a = 1'b1;
        repeat (13000) cyc();
        phase_a = 1'b0;

        pause = 1'b1;
        next_cap(g0);
        repeat (3) begin
            next_cap(g);
            check("pause_hold", g, g0);
        end

        step = 1'b1; repeat (3) cyc(); step = 1'b0;
        next_cap(g);
        check("step_pulse", g, 5'(g0 + 5'd1));

        repeat (4) begin
            step = 1'b1; repeat (4) cyc();
            step = 1'b0; repeat (4) cyc();
        end
        next_cap(g);
        check("step_multi", g, 5'(g0 + 5'd2));

        step = 1'b1;
        next_cap(g);
        check("step_hold_first", g, 5'(g0 + 5'd3));
        repeat (2) begin
            next_cap(g);
            check("step_hold_more", g, 5'(g0 + 5'd3));
        end
        step = 1'b0;

        budget = S_FT + 10;
        while (n_m[1] != S_FT - 3 && budget > 0) begin
            cyc();
            budget--;
        end
        check("align_frame_end", n_m[1], S_FT - 3);
        step = 1'b1; repeat (5) cyc(); step = 1'b0;
        next_cap(g);
        check("step_at_fe_deferred", g, 5'(g0 + 5'd3));
        next_cap(g);
        check("step_at_fe_applied", g, 5'(g0 + 5'd4));

        pause = 1'b0;
        next_cap(g);
        check("unpause", g, 5'(g0 + 5'd5));

        budget = 900;
        while ((n_m[0] % 800) != 700 && budget > 0) begin
            cyc();
            budget--;
        end
        rst = 1'b1;
        cyc();
        check("rst_mid_full", vga_full, 7'b1100000);
        check("rst_mid_small", vga_small, 7'b1100000);
        rst = 1'b0;

        repeat (20000) begin
            if ($urandom_range(0, 599) == 0) pause = ~pause;
            if ($urandom_range(0, 99) < 3) step = ~step;
            rst = ($urandom_range(0, 7999) == 0);
            cyc();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/archel.md
ARCHEL -- requirements
Module: archel

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock, pixel clock (25 MHz nominal); all logic on rising edge.
REQ-002 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port PAUSE, input, 1 bit: level-sensitive; high freezes the animation generation counter.
REQ-004 SHALL have port STEP, input, 1 bit: while PAUSE=1, each rising edge requests one generation advance.
REQ-005 SHALL have port VGA, output, 7 bits: [6]=HS, [5]=VS (both active-low), [4:3]=R, [2:1]=G, [0]=B.

Function
REQ-006 SHALL keep a 10-bit horizontal counter h, 0..799, wrapping 799->0 every cycle.
REQ-007 SHALL keep a 10-bit vertical counter v, 0..524, incrementing when h=799 and wrapping 524->0.
REQ-008 SHALL assert HS low for h in 656..751 and VS low for v in 490..491; both high otherwise.
REQ-009 SHALL define the visible region as h<640 and v<480; color SHALL be 5'b00000 outside it.
REQ-010 SHALL compute visible color as c = (h[8:4] XOR v[8:4]) + gen[4:0], mod 32, mapped {R,G,B}=c[4:0].
REQ-011 SHALL register VGA, so the output lags counter state by exactly 1 cycle; HS, VS and color SHALL stay aligned.
REQ-012 SHALL keep an 8-bit generation counter gen, updated only at frame end (h=799 and v=524), wrapping 255->0.
REQ-013 With PAUSE=0, gen SHALL increment at every frame end; pending step requests SHALL be cleared.
REQ-014 SHALL synchronise STEP through a 2-flop synchroniser and detect its rising edge.
REQ-015 With PAUSE=1, a detected STEP edge SHALL set a pending flag; at the next frame end gen SHALL increment once and the flag SHALL clear.
REQ-016 Multiple STEP edges within one frame SHALL yield one increment; STEP held high SHALL yield one increment total.
REQ-017 A STEP edge coinciding with a frame end SHALL be applied at the following frame end.
REQ-018 PAUSE changes SHALL take effect at the next frame end; no mid-frame gen change SHALL ever occur.

Reset
REQ-019 On RST=1, h, v, gen, the pending flag and the synchroniser SHALL clear to 0.
REQ-020 On the cycle after a reset edge, VGA SHALL equal 7'b1100000.
REQ-021 RST asserted mid-frame SHALL restart timing at h=0, v=0, gen=0, with no partial sync pulse after the reset edge.

Configuration
REQ-022 With macro ARCHEL_BORDER_EN defined, visible pixels with h=0, h=639, v=0 or v=479 SHALL output color 5'b11111, overriding REQ-010.
REQ-023 Without ARCHEL_BORDER_EN, no border logic SHALL be present and REQ-010 SHALL apply across the whole visible region.

Structure
REQ-024 Package archel_pkg SHALL hold the timing constants: H_VIS=640, H_FP=16, H_SYNC=96, H_TOTAL=800, V_VIS=480, V_FP=10, V_SYNC=2, V_TOTAL=525.
REQ-025 archel_pkg SHALL also hold the color width (5) and the generation width (8).
REQ-026 Sub-module archel_vga_timing SHALL contain h/v counters, sync decode, visible flag and frame-end strobe; archel SHALL add the generation control and pixel pattern.

Verification
REQ-027 Reset: RST=1 for 1 cycle -> VGA=7'b1100000 on the next cycle, h=0, v=0, gen=0.
REQ-028 Sync: free-run 2 frames -> HS low for exactly 96 of every 800 cycles; VS low for exactly 1600 of every 420000 cycles.
REQ-029 Pattern: frame 0 -> pixel (0,0)=0, (16,0)=1, (16,16)=0; frame 1 -> pixel (0,0)=1.
REQ-030 Pause/step: PAUSE=1 for 3 frames with no STEP -> gen unchanged.
REQ-031 Pause/step: one STEP pulse, then STEP held high 3 frames -> gen +1 total.
REQ-032 Border: ARCHEL_BORDER_EN defined -> pixel (0,0) and (639,479)=5'b11111; undefined -> pixel (0,0)=0 at gen=0.
